// File: rtl/multi_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// multi_alarm_ctrl
//   Multi-channel alarm clock controller. Each channel stores an alarm time and
//   an arm flag. A match on a sec_tick cycle latches a pending bit. A single
//   ring/snooze state machine services pending channels one at a time, always
//   taking the lowest pending index first.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   sec_tick, cur_time  : one-second pulse and current time of day (seconds)
//   wr_en/ch/time/arm   : channel configuration write (out-of-range time ignored)
//   key_stop/key_snooze : debounced one-cycle key pulses
//   rd_ch, rd_time      : combinational read-back of a stored alarm time
//   armed, pending      : per-channel arm and matched-not-yet-serviced flags
//   ringing, snoozing   : FSM in RING / SNOOZE
//   active_ch           : channel being serviced (valid while ringing/snoozing)
// -----------------------------------------------------------------------------
module multi_alarm_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int TIME_W      = 17,
  parameter int DAY_SECONDS = 86400,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_SEC  = 300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_tick,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              wr_arm,
  input  logic              key_stop,
  input  logic              key_snooze,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [TIME_W-1:0] rd_time,
  output logic [NUM_CH-1:0] armed,
  output logic [NUM_CH-1:0] pending,
  output logic              ringing,
  output logic              snoozing,
  output logic [CH_W-1:0]   active_ch
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Terminal counts are compared before incrementing, so a counter leaves its
  // state on the tick that would make it reach the limit and never wraps.
  localparam logic [CNT_W-1:0]  RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0]  SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [TIME_W:0]   DAY_LIM     = (TIME_W + 1)'(DAY_SECONDS);
  localparam logic [CH_W:0]     CH_LIM      = (CH_W + 1)'(NUM_CH);

  logic [TIME_W-1:0] alarm_time_q [NUM_CH];
  logic [NUM_CH-1:0] armed_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]  snz_cnt_q, snz_cnt_d;

  logic              wr_valid;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] match_vec;
  logic [NUM_CH-1:0] disarm_vec;
  logic [NUM_CH-1:0] pend_avail;
  logic [CH_W-1:0]   first_ch;
  logic              active_disarm;
  logic              svc_clear;

  assign wr_valid = wr_en && ({1'b0, wr_time} < DAY_LIM);

  // Per-channel decode; matching uses the registered (pre-write) values.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_sel[gi]     = wr_valid && (wr_ch == CH_W'(gi));
      assign disarm_vec[gi] = wr_sel[gi] && !wr_arm;
      assign match_vec[gi]  = sec_tick && armed_q[gi] && (alarm_time_q[gi] == cur_time);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) alarm_time_q[i] <= '0;
      armed_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          alarm_time_q[i] <= wr_time;
          armed_q[i]      <= wr_arm;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_ch_d   = active_ch_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    svc_clear     = 1'b0;
    // A channel being disarmed this cycle must not be picked for service.
    pend_avail    = pending_q & ~disarm_vec;
    active_disarm = disarm_vec[active_ch_q];
    first_ch      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_avail[i]) first_ch = CH_W'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (|pend_avail) begin
          state_d     = ST_RING;
          active_ch_d = first_ch;
          ring_cnt_d  = '0;
        end
      end
      ST_RING: begin
        if (key_stop || active_disarm) begin
          svc_clear  = 1'b1;
          state_d    = ST_IDLE;
          ring_cnt_d = '0;
        end else if (key_snooze) begin
          state_d    = ST_SNOOZE;
          snz_cnt_d  = '0;
          ring_cnt_d = '0;
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            svc_clear  = 1'b1;
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (key_stop || active_disarm) begin
          svc_clear = 1'b1;
          state_d   = ST_IDLE;
          snz_cnt_d = '0;
        end else if (sec_tick) begin
          if (snz_cnt_q == SNOOZE_LAST) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ring_cnt_d = '0;
        snz_cnt_d  = '0;
      end
    endcase

    // Pending bits are set-only; they clear on disarm or end of service.
    pending_d = (pending_q | match_vec) & ~disarm_vec;
    if (svc_clear) pending_d[active_ch_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      active_ch_q <= '0;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign rd_time   = ({1'b0, rd_ch} < CH_LIM) ? alarm_time_q[rd_ch] : '0;
  assign armed     = armed_q;
  assign pending   = pending_q;
  assign ringing   = (state_q == ST_RING);
  assign snoozing  = (state_q == ST_SNOOZE);
  assign active_ch = active_ch_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_alarm_ctrl
//   Directed testbench for multi_alarm_ctrl with RING_SEC=3, SNOOZE_SEC=2.
//   Inputs are driven 1 ns after a rising edge; outputs are sampled at the
//   same point, i.e. after the edge that consumed the previous stimulus.
// -----------------------------------------------------------------------------
module tb_multi_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec_tick = 1'b0;
  logic [16:0] cur_time = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [16:0] wr_time = '0;
  logic        wr_arm = 1'b0;
  logic        key_stop = 1'b0;
  logic        key_snooze = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [16:0] rd_time;
  logic [3:0]  armed;
  logic [3:0]  pending;
  logic        ringing;
  logic        snoozing;
  logic [1:0]  active_ch;

  int checks = 0;
  int passed = 0;

  multi_alarm_ctrl #(
    .NUM_CH(4), .CH_W(2), .TIME_W(17), .DAY_SECONDS(86400),
    .RING_SEC(3), .SNOOZE_SEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .cur_time(cur_time),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_time(wr_time), .wr_arm(wr_arm),
    .key_stop(key_stop), .key_snooze(key_snooze), .rd_ch(rd_ch),
    .rd_time(rd_time), .armed(armed), .pending(pending), .ringing(ringing),
    .snoozing(snoozing), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [16:0] t, input logic arm);
    wr_en = 1'b1; wr_ch = ch; wr_time = t; wr_arm = arm;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_tick(input logic [16:0] t);
    cur_time = t; sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic press(input logic stop, input logic snz);
    key_stop = stop; key_snooze = snz;
    step();
    key_stop = 1'b0; key_snooze = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({ringing, snoozing, pending, armed, active_ch} !== 11'd0)
      $display("FAIL reset_outputs: got r=%b s=%b p=%b a=%b ch=%0d, want all 0", ringing, snoozing, pending, armed, active_ch);
    else passed++;
    checks++; if (rd_time !== 17'd0) $display("FAIL reset_rd_time: got %0d want 0", rd_time); else passed++;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (ringing !== 1'b0) $display("FAIL reset_release_ringing: got %b want 0", ringing); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single_match();
    do_write(2'd1, 17'd3600, 1'b1);
    rd_ch = 2'd1; #1;
    checks++; if (rd_time !== 17'd3600) $display("FAIL wr_rd_time: got %0d want 3600", rd_time); else passed++;
    checks++; if (armed !== 4'b0010) $display("FAIL wr_armed: got %b want 0010", armed); else passed++;
    do_tick(17'd3600);
    checks++; if (pending !== 4'b0010) $display("FAIL match_pending: got %b want 0010", pending); else passed++;
    checks++; if (ringing !== 1'b0) $display("FAIL match_not_yet_ringing: got %b want 0", ringing); else passed++;
    step();
    checks++; if (ringing !== 1'b1 || active_ch !== 2'd1)
      $display("FAIL match_ringing: got r=%b ch=%0d want r=1 ch=1", ringing, active_ch);
    else passed++;
    press(1'b1, 1'b0);
    checks++; if (ringing !== 1'b0 || pending !== 4'b0000)
      $display("FAIL match_stop: got r=%b p=%b want r=0 p=0000", ringing, pending);
    else passed++;
    $display("test_single_match done");
  endtask

  task automatic test_two_channels();
    do_write(2'd0, 17'd100, 1'b1);
    do_write(2'd2, 17'd100, 1'b1);
    do_tick(17'd100);
    checks++; if (pending !== 4'b0101) $display("FAIL two_pending: got %b want 0101", pending); else passed++;
    step();
    checks++; if (ringing !== 1'b1 || active_ch !== 2'd0)
      $display("FAIL two_first_ch0: got r=%b ch=%0d want r=1 ch=0", ringing, active_ch);
    else passed++;
    press(1'b1, 1'b0);
    checks++; if (ringing !== 1'b0 || pending !== 4'b0100)
      $display("FAIL two_after_stop: got r=%b p=%b want r=0 p=0100", ringing, pending);
    else passed++;
    step();
    checks++; if (ringing !== 1'b1 || active_ch !== 2'd2)
      $display("FAIL two_then_ch2: got r=%b ch=%0d want r=1 ch=2", ringing, active_ch);
    else passed++;
    press(1'b1, 1'b0);
    checks++; if (pending !== 4'b0000 || ringing !== 1'b0)
      $display("FAIL two_all_clear: got r=%b p=%b want r=0 p=0000", ringing, pending);
    else passed++;
    $display("test_two_channels done");
  endtask

  task automatic test_auto_stop();
    do_write(2'd3, 17'd200, 1'b1);
    do_tick(17'd200);
    step();
    checks++; if (ringing !== 1'b1 || active_ch !== 2'd3)
      $display("FAIL auto_ringing: got r=%b ch=%0d want r=1 ch=3", ringing, active_ch);
    else passed++;
    do_tick(17'd201);
    do_tick(17'd202);
    checks++; if (ringing !== 1'b1) $display("FAIL auto_still_ringing: got %b want 1", ringing); else passed++;
    do_tick(17'd203);
    checks++; if (ringing !== 1'b0 || pending !== 4'b0000)
      $display("FAIL auto_stopped: got r=%b p=%b want r=0 p=0000", ringing, pending);
    else passed++;
    $display("test_auto_stop done");
  endtask

  task automatic test_snooze();
    do_write(2'd3, 17'd300, 1'b1);
    do_tick(17'd300);
    step();
    press(1'b0, 1'b1);
    checks++; if (snoozing !== 1'b1 || ringing !== 1'b0 || pending !== 4'b1000)
      $display("FAIL snz_enter: got s=%b r=%b p=%b want s=1 r=0 p=1000", snoozing, ringing, pending);
    else passed++;
    press(1'b0, 1'b1);
    checks++; if (snoozing !== 1'b1) $display("FAIL snz_key_ignored: got %b want 1", snoozing); else passed++;
    do_tick(17'd301);
    checks++; if (snoozing !== 1'b1) $display("FAIL snz_one_tick: got %b want 1", snoozing); else passed++;
    do_tick(17'd302);
    checks++; if (ringing !== 1'b1 || snoozing !== 1'b0 || active_ch !== 2'd3)
      $display("FAIL snz_reenter: got r=%b s=%b ch=%0d want r=1 s=0 ch=3", ringing, snoozing, active_ch);
    else passed++;
    // ch1 matches while ch3 rings; it waits and is serviced afterwards.
    do_tick(17'd3600);
    checks++; if (pending !== 4'b1010 || active_ch !== 2'd3)
      $display("FAIL snz_queue: got p=%b ch=%0d want p=1010 ch=3", pending, active_ch);
    else passed++;
    press(1'b1, 1'b0);
    step();
    checks++; if (ringing !== 1'b1 || active_ch !== 2'd1 || pending !== 4'b0010)
      $display("FAIL snz_next_ch1: got r=%b ch=%0d p=%b want r=1 ch=1 p=0010", ringing, active_ch, pending);
    else passed++;
    press(1'b1, 1'b0);
    $display("test_snooze done");
  endtask

  task automatic test_both_keys();
    do_tick(17'd300);
    step();
    press(1'b1, 1'b1);
    checks++; if (ringing !== 1'b0 || snoozing !== 1'b0 || pending !== 4'b0000)
      $display("FAIL both_keys: got r=%b s=%b p=%b want r=0 s=0 p=0000", ringing, snoozing, pending);
    else passed++;
    $display("test_both_keys done");
  endtask

  task automatic test_idle_keys();
    press(1'b1, 1'b1);
    checks++; if (ringing !== 1'b0 || snoozing !== 1'b0)
      $display("FAIL idle_keys: got r=%b s=%b want r=0 s=0", ringing, snoozing);
    else passed++;
    $display("test_idle_keys done");
  endtask

  task automatic test_disarm();
    do_tick(17'd300);
    step();
    do_write(2'd3, 17'd300, 1'b0);
    checks++; if (ringing !== 1'b0 || pending !== 4'b0000 || armed[3] !== 1'b0)
      $display("FAIL disarm_active: got r=%b p=%b a=%b want r=0 p=0000 a[3]=0", ringing, pending, armed);
    else passed++;
    do_tick(17'd100);
    step();
    do_write(2'd2, 17'd100, 1'b0);
    checks++; if (pending !== 4'b0001 || ringing !== 1'b1 || active_ch !== 2'd0)
      $display("FAIL disarm_other: got p=%b r=%b ch=%0d want p=0001 r=1 ch=0", pending, ringing, active_ch);
    else passed++;
    press(1'b1, 1'b0);
    step();
    checks++; if (ringing !== 1'b0 || pending !== 4'b0000)
      $display("FAIL disarm_no_ring: got r=%b p=%b want r=0 p=0000", ringing, pending);
    else passed++;
    $display("test_disarm done");
  endtask

  task automatic test_bad_write_and_async_reset();
    rd_ch = 2'd1;
    do_write(2'd1, 17'd86400, 1'b0);
    checks++; if (rd_time !== 17'd3600 || armed[1] !== 1'b1)
      $display("FAIL bad_write_ignored: got t=%0d a=%b want t=3600 a[1]=1", rd_time, armed);
    else passed++;
    do_tick(17'd100);
    step();
    press(1'b0, 1'b1);
    checks++; if (snoozing !== 1'b1) $display("FAIL pre_reset_snooze: got %b want 1", snoozing); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ringing, snoozing, pending, armed, active_ch} !== 11'd0 || rd_time !== 17'd0)
      $display("FAIL async_reset: got r=%b s=%b p=%b a=%b ch=%0d t=%0d want all 0", ringing, snoozing, pending, armed, active_ch, rd_time);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (snoozing !== 1'b0 || ringing !== 1'b0)
      $display("FAIL post_reset_idle: got r=%b s=%b want 0 0", ringing, snoozing);
    else passed++;
    $display("test_bad_write_and_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_two_channels();
    test_auto_stop();
    test_snooze();
    test_both_keys();
    test_idle_keys();
    test_disarm();
    test_bad_write_and_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
